touch_panel_spi_responder: RTL and testbench

// - SPI slave emulating the XPT2046/ADS7843 touch controller; the responding end of the touch_panel SPI master and busy/pen_irq_n PIOs.
// - Used in simulation and in HW loop-back builds to replace the LT24 touch chip; feeds scripted pen coordinates to the Nios driver.
// - Oversamples SCLK/SS_n/MOSI with clk_clk. Requires clk_clk >= 8x SCLK, SPI mode 0.

---
 rtl/touch_panel_pkg.sv | 41 ++++
 rtl/tp_spi_sync_edge.sv | 58 +++++
 rtl/touch_panel_spi_responder.sv | 215 +++++++++++++++++++++
 tb/tb_touch_panel_spi_responder.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/touch_panel_pkg.sv
// touch_panel_pkg
// Shared definitions for the XPT2046/ADS7843 touch-controller responder:
//   - channel codes carried in the A2:A0 field of the control byte
//   - bit positions of the control-byte fields {S, A2:A0, MODE, SER/DFR, PD1, PD0}
//   - fixed auxiliary conversion results
//   - data-side FSM state type
// No ports; imported by every file of the responder.

package touch_panel_pkg;

    // Channel codes (A2:A0)
    localparam logic [2:0] CH_TEMP0 = 3'b000;
    localparam logic [2:0] CH_Y     = 3'b001;
    localparam logic [2:0] CH_VBAT  = 3'b010;
    localparam logic [2:0] CH_Z1    = 3'b011;
    localparam logic [2:0] CH_Z2    = 3'b100;
    localparam logic [2:0] CH_X     = 3'b101;
    localparam logic [2:0] CH_AUX   = 3'b110;
    localparam logic [2:0] CH_TEMP1 = 3'b111;

    // Control-byte field bit indices (MSB is transmitted first)
    localparam int CTRL_S_BIT    = 7;
    localparam int CTRL_A_MSB    = 6;
    localparam int CTRL_A_LSB    = 4;
    localparam int CTRL_MODE_BIT = 3;
    localparam int CTRL_SER_BIT  = 2;
    localparam int CTRL_PD1_BIT  = 1;
    localparam int CTRL_PD0_BIT  = 0;

    // Fixed results for the auxiliary channels
    localparam logic [11:0] VBAT_VALUE   = 12'h800;
    localparam logic [11:0] AUX_VALUE    = 12'h400;
    localparam logic [11:0] TEMP1_OFFSET = 12'h040;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_SHIFT = 2'd2
    } tp_state_e;

endpackage

// File: rtl/tp_spi_sync_edge.sv
// tp_spi_sync_edge
// Brings one asynchronous SPI pin into the clk domain through SYNC_STAGES
// flip-flops and produces single-cycle rise/fall pulses. The level output is
// delayed one extra stage so that level, rise and fall are mutually aligned:
// all three reflect a pin edge SYNC_STAGES+1 clk cycles after it happens.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous reset, active low (chain resets to RESET_VAL)
//   din    in  asynchronous pin
//   level  out synchronised level, aligned with the pulses
//   rise   out one-cycle pulse on a 0->1 pin transition
//   fall   out one-cycle pulse on a 1->0 pin transition

module tp_spi_sync_edge
    import touch_panel_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], din};
        level_d = sync_q[SYNC_STAGES-1];
        rise_d  = sync_q[SYNC_STAGES-1] & ~level_q;
        fall_d  = ~sync_q[SYNC_STAGES-1] & level_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= {SYNC_STAGES{RESET_VAL}};
            level_q <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/touch_panel_spi_responder.sv
// touch_panel_spi_responder
// SPI mode-0 slave that emulates an XPT2046/ADS7843 touch controller and
// returns scripted pen coordinates. SCLK, SS_n and MOSI are oversampled with
// clk_clk (clk_clk must be at least 8x SCLK).
// Build option: define TOUCH_PANEL_RESPONDER_AUX_EN to return fixed VBAT/AUX
// results and to distinguish TEMP1 (SER/DFR=1 on A=000/111).
// Ports:
//   clk_clk, reset_reset_n          clock, asynchronous active-low reset
//   spi_sclk, spi_mosi, spi_ss_n    SPI inputs from the master
//   spi_miso                        conversion data to the master
//   busy, pen_irq_n                 status lines to the host PIOs
//   pen_down, touch_x/y/z1/z2       scripted touch inputs
//   cmd_valid, cmd_byte             completed control byte pulse / held value

module touch_panel_spi_responder
    import touch_panel_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [11:0] TEMP_VALUE  = 12'h2A0,
    parameter logic [11:0] Z2_IDLE     = 12'hFFF
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    input  logic        spi_ss_n,
    output logic        spi_miso,
    output logic        busy,
    output logic        pen_irq_n,
    input  logic        pen_down,
    input  logic [11:0] touch_x,
    input  logic [11:0] touch_y,
    input  logic [11:0] touch_z1,
    input  logic [11:0] touch_z2,
    output logic        cmd_valid,
    output logic [7:0]  cmd_byte
);

    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic ss_n_level, ss_n_rise_unused, ss_n_fall_unused;
    logic mosi_level, mosi_rise_unused, mosi_fall_unused;

    tp_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk_clk), .rst_n(reset_reset_n), .din(spi_sclk),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    // SS_n resets to the deselected level so nothing is decoded until the pin is seen low.
    tp_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss_n (
        .clk(clk_clk), .rst_n(reset_reset_n), .din(spi_ss_n),
        .level(ss_n_level), .rise(ss_n_rise_unused), .fall(ss_n_fall_unused)
    );

    tp_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk_clk), .rst_n(reset_reset_n), .din(spi_mosi),
        .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    tp_state_e   state_q, state_d;
    logic        cmd_active_q, cmd_active_d;
    logic [2:0]  cmd_cnt_q, cmd_cnt_d;
    logic [6:0]  cmd_sr_q, cmd_sr_d;
    logic [7:0]  cmd_byte_q, cmd_byte_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        irq_en_q, irq_en_d;
    logic [11:0] data_sr_q, data_sr_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        miso_q, miso_d;
    logic        busy_q, busy_d;
    logic        pen_irq_n_q, pen_irq_n_d;

    logic [7:0]  new_byte;
    logic [11:0] chan_value;

    // The byte that completes if the current rise is the 8th: 7 stored bits plus live MOSI.
    assign new_byte = {cmd_sr_q, mosi_level};

    // Conversion result for the completing byte, sampled from the scripted inputs this cycle.
    always_comb begin
        chan_value = 12'h000;
        case (new_byte[CTRL_A_MSB:CTRL_A_LSB])
            CH_X:     chan_value = pen_down ? touch_x  : 12'h000;
            CH_Y:     chan_value = pen_down ? touch_y  : 12'h000;
            CH_Z1:    chan_value = pen_down ? touch_z1 : 12'h000;
            CH_Z2:    chan_value = pen_down ? touch_z2 : Z2_IDLE;
`ifdef TOUCH_PANEL_RESPONDER_AUX_EN
            CH_TEMP0: chan_value = new_byte[CTRL_SER_BIT] ? (TEMP_VALUE + TEMP1_OFFSET) : TEMP_VALUE;
            CH_VBAT:  chan_value = VBAT_VALUE;
            CH_AUX:   chan_value = AUX_VALUE;
            CH_TEMP1: chan_value = new_byte[CTRL_SER_BIT] ? (TEMP_VALUE + TEMP1_OFFSET) : 12'h000;
`else
            CH_TEMP0: chan_value = TEMP_VALUE;
`endif
            default:  chan_value = 12'h000;
        endcase
    end

    // Next-state logic. The command shifter (rises) and the data FSM (falls) are
    // independent so a new control byte can be clocked in while the previous word
    // is still shifting out; a byte completing mid-word restarts the conversion.
    always_comb begin
        state_d      = state_q;
        cmd_active_d = cmd_active_q;
        cmd_cnt_d    = cmd_cnt_q;
        cmd_sr_d     = cmd_sr_q;
        cmd_byte_d   = cmd_byte_q;
        cmd_valid_d  = 1'b0;
        irq_en_d     = irq_en_q;
        data_sr_d    = data_sr_q;
        bit_cnt_d    = bit_cnt_q;
        miso_d       = miso_q;
        busy_d       = busy_q;

        if (ss_n_level) begin
            // Deselected: abandon everything except the last byte and the IRQ enable.
            cmd_active_d = 1'b0;
            cmd_cnt_d    = 3'd0;
            cmd_sr_d     = 7'h00;
            state_d      = ST_IDLE;
            miso_d       = 1'b0;
            busy_d       = 1'b0;
            bit_cnt_d    = 4'd0;
        end else begin
            if (sclk_rise) begin
                if (!cmd_active_q) begin
                    if (mosi_level) begin
                        cmd_active_d = 1'b1;
                        cmd_cnt_d    = 3'd1;
                        cmd_sr_d     = 7'h01;
                    end
                end else if (cmd_cnt_q == 3'd7) begin
                    cmd_active_d = 1'b0;
                    cmd_cnt_d    = 3'd0;
                    cmd_byte_d   = new_byte;
                    cmd_valid_d  = 1'b1;
                    irq_en_d     = ~new_byte[CTRL_PD0_BIT];
                    data_sr_d    = chan_value;
                    state_d      = ST_CONV;
                    busy_d       = 1'b0;
                    miso_d       = 1'b0;
                end else begin
                    cmd_sr_d  = {cmd_sr_q[5:0], mosi_level};
                    cmd_cnt_d = cmd_cnt_q + 3'd1;
                end
            end

            // CONV spends one SCLK with busy high: first fall raises it, second starts the word.
            if (sclk_fall) begin
                case (state_q)
                    ST_CONV: begin
                        if (!busy_q) begin
                            busy_d = 1'b1;
                        end else begin
                            busy_d    = 1'b0;
                            state_d   = ST_SHIFT;
                            miso_d    = data_sr_q[11];
                            data_sr_d = {data_sr_q[10:0], 1'b0};
                            bit_cnt_d = cmd_byte_q[CTRL_MODE_BIT] ? 4'd7 : 4'd11;
                        end
                    end
                    ST_SHIFT: begin
                        if (bit_cnt_q == 4'd0) begin
                            miso_d  = 1'b0;
                            state_d = ST_IDLE;
                        end else begin
                            miso_d    = data_sr_q[11];
                            data_sr_d = {data_sr_q[10:0], 1'b0};
                            bit_cnt_d = bit_cnt_q - 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        pen_irq_n_d = (state_d != ST_IDLE) ? 1'b1 : ~(pen_down & irq_en_d);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q      <= ST_IDLE;
            cmd_active_q <= 1'b0;
            cmd_cnt_q    <= 3'd0;
            cmd_sr_q     <= 7'h00;
            cmd_byte_q   <= 8'h00;
            cmd_valid_q  <= 1'b0;
            irq_en_q     <= 1'b1;
            data_sr_q    <= 12'h000;
            bit_cnt_q    <= 4'd0;
            miso_q       <= 1'b0;
            busy_q       <= 1'b0;
            pen_irq_n_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            cmd_active_q <= cmd_active_d;
            cmd_cnt_q    <= cmd_cnt_d;
            cmd_sr_q     <= cmd_sr_d;
            cmd_byte_q   <= cmd_byte_d;
            cmd_valid_q  <= cmd_valid_d;
            irq_en_q     <= irq_en_d;
            data_sr_q    <= data_sr_d;
            bit_cnt_q    <= bit_cnt_d;
            miso_q       <= miso_d;
            busy_q       <= busy_d;
            pen_irq_n_q  <= pen_irq_n_d;
        end
    end

    assign spi_miso  = miso_q;
    assign busy      = busy_q;
    assign pen_irq_n = pen_irq_n_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_byte  = cmd_byte_q;

endmodule

// File: tb/tb_touch_panel_spi_responder.sv
// tb_touch_panel_spi_responder
// Directed bench for touch_panel_spi_responder acting as the SPI master.
// Expected conversion words are queued when a control byte is placed on MOSI
// and popped when the corresponding MISO bits have been collected.

module tb_touch_panel_spi_responder;

    localparam int          HALF   = 8;
    localparam logic [11:0] X_VAL  = 12'hA5C;
    localparam logic [11:0] Y_VAL  = 12'h3F7;
    localparam logic [11:0] Z1_VAL = 12'h123;
    localparam logic [11:0] Z2_VAL = 12'h456;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_ss_n;
    logic        spi_miso;
    logic        busy;
    logic        pen_irq_n;
    logic        pen_down;
    logic [11:0] touch_x;
    logic [11:0] touch_y;
    logic [11:0] touch_z1;
    logic [11:0] touch_z2;
    logic        cmd_valid;
    logic [7:0]  cmd_byte;

    typedef struct {
        logic [11:0] word;
        int          nbits;
    } exp_t;

    exp_t exp_q[$];

    int   vectors     = 0;
    int   miscompares = 0;
    int   valid_total = 0;
    int   valid_mark  = 0;

    logic mosi_bits [64];
    logic miso_bits [64];
    logic busy_bits [64];
    logic pirq_bits [64];

    // 100 MHz system clock; SCLK is generated at 1/16 of it
    always #5 clk_clk = ~clk_clk;

    touch_panel_spi_responder dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .spi_sclk      (spi_sclk),
        .spi_mosi      (spi_mosi),
        .spi_ss_n      (spi_ss_n),
        .spi_miso      (spi_miso),
        .busy          (busy),
        .pen_irq_n     (pen_irq_n),
        .pen_down      (pen_down),
        .touch_x       (touch_x),
        .touch_y       (touch_y),
        .touch_z1      (touch_z1),
        .touch_z2      (touch_z2),
        .cmd_valid     (cmd_valid),
        .cmd_byte      (cmd_byte)
    );

    // Running count of cmd_valid pulses, sampled away from the active edge
    always @(negedge clk_clk) begin
        if (cmd_valid === 1'b1) valid_total <= valid_total + 1;
    end

    // One comparison point: counts the vector and reports any miscompare
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Empties the MOSI script for the next frame
    task automatic clearBits();
        for (int i = 0; i < 64; i++) mosi_bits[i] = 1'b0;
    endtask

    // Places a control byte starting at SCLK number start_clk and queues its expected word
    task automatic setCmd(input int start_clk, input logic [7:0] ctrl, input logic [11:0] word, input int nbits);
        exp_t e;
        for (int b = 0; b < 8; b++) mosi_bits[start_clk - 1 + b] = ctrl[7 - b];
        if (nbits > 0) begin
            e.word  = word;
            e.nbits = nbits;
            exp_q.push_back(e);
        end
    endtask

    // Clocks SCLK numbers first_clk..last_clk; MISO/busy/pen_irq_n are recorded just before each rise
    task automatic applyStimulus(input int first_clk, input int last_clk, input bit ss_with_first);
        for (int c = first_clk; c <= last_clk; c++) begin
            spi_mosi = mosi_bits[c - 1];
            repeat (HALF) @(negedge clk_clk);
            miso_bits[c - 1] = spi_miso;
            busy_bits[c - 1] = busy;
            pirq_bits[c - 1] = pen_irq_n;
            if (ss_with_first && c == first_clk) spi_ss_n = 1'b0;
            spi_sclk = 1'b1;
            repeat (HALF) @(negedge clk_clk);
            spi_sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk_clk);
        spi_mosi = 1'b0;
    endtask

    function automatic logic [11:0] getWord(input int first_clk, input int nbits);
        logic [11:0] w;
        w = 12'h000;
        for (int k = 0; k < nbits; k++) w = {w[10:0], miso_bits[first_clk - 1 + k]};
        return w;
    endfunction

    function automatic int onesMiso(input int first_clk, input int last_clk);
        int n;
        n = 0;
        for (int c = first_clk; c <= last_clk; c++) if (miso_bits[c - 1] !== 1'b0) n++;
        return n;
    endfunction

    function automatic int onesBusy(input int first_clk, input int last_clk);
        int n;
        n = 0;
        for (int c = first_clk; c <= last_clk; c++) if (busy_bits[c - 1] !== 1'b0) n++;
        return n;
    endfunction

    // Pops the oldest expected word and compares it with the MISO bits from first_clk on
    task automatic checkWord(input string tag, input int first_clk);
        exp_t e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL %s observed=no-expected-word expected=queued-word", tag);
        end else begin
            e = exp_q.pop_front();
            checkOutput(tag, 32'(getWord(first_clk, e.nbits)), 32'(e.word));
        end
    endtask

    initial begin
        reset_reset_n = 1'b0;
        spi_sclk      = 1'b0;
        spi_mosi      = 1'b0;
        spi_ss_n      = 1'b1;
        pen_down      = 1'b0;
        touch_x       = X_VAL;
        touch_y       = Y_VAL;
        touch_z1      = Z1_VAL;
        touch_z2      = Z2_VAL;
        clearBits();

        // Reset values
        repeat (5) @(negedge clk_clk);
        checkOutput("rst_miso", 32'(spi_miso), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_pen_irq_n", 32'(pen_irq_n), 32'd1);
        checkOutput("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        checkOutput("rst_cmd_byte", 32'(cmd_byte), 32'h00);
        reset_reset_n = 1'b1;
        repeat (5) @(negedge clk_clk);

        // Pen contact with IRQ enabled out of reset
        pen_down = 1'b1;
        repeat (5) @(negedge clk_clk);
        checkOutput("irq_idle_pen", 32'(pen_irq_n), 32'd0);

        // Plain X conversion; touch_x changes after the byte must not alter the word
        spi_ss_n = 1'b0;
        repeat (5) @(negedge clk_clk);
        clearBits();
        setCmd(1, 8'hD0, X_VAL, 12);
        valid_mark = valid_total;
        applyStimulus(1, 9, 1'b0);
        touch_x = 12'h000;
        applyStimulus(10, 24, 1'b0);
        touch_x = X_VAL;
        checkOutput("x_valid_cnt", 32'(valid_total - valid_mark), 32'd1);
        checkOutput("x_cmd_byte", 32'(cmd_byte), 32'hD0);
        checkOutput("x_busy_sclks", 32'(onesBusy(1, 24)), 32'd1);
        checkOutput("x_busy_at9", 32'(busy_bits[8]), 32'd1);
        checkWord("x_word", 10);
        checkOutput("x_tail_zero", 32'(onesMiso(22, 24)), 32'd0);
        checkOutput("x_irq_before", 32'(pirq_bits[0]), 32'd0);
        checkOutput("x_irq_shift", 32'(pirq_bits[11]), 32'd1);
        checkOutput("x_irq_after", 32'(pen_irq_n), 32'd0);

        // Y in 8-bit mode returns the upper byte only
        clearBits();
        setCmd(1, 8'h98, 12'(Y_VAL >> 4), 8);
        applyStimulus(1, 24, 1'b0);
        checkWord("y8_word", 10);
        checkOutput("y8_tail_zero", 32'(onesMiso(18, 24)), 32'd0);
        checkOutput("y8_busy_sclks", 32'(onesBusy(1, 24)), 32'd1);

        // PD0=1 disables the pen interrupt
        pen_down = 1'b0;
        clearBits();
        setCmd(1, 8'hD1, 12'h000, 12);
        applyStimulus(1, 24, 1'b0);
        checkWord("x_penup_word", 10);
        pen_down = 1'b1;
        repeat (10) @(negedge clk_clk);
        checkOutput("irq_disabled", 32'(pen_irq_n), 32'd1);

        // PD0=0 re-enables it, still forced inactive while converting
        clearBits();
        setCmd(1, 8'hD0, X_VAL, 12);
        applyStimulus(1, 24, 1'b0);
        checkWord("x_reen_word", 10);
        checkOutput("irq_reen_conv", 32'(pirq_bits[8]), 32'd1);
        checkOutput("irq_reen_after", 32'(pen_irq_n), 32'd0);

        // 16-clock overlapped frames X, Y, X
        clearBits();
        setCmd(1, 8'hD0, X_VAL, 12);
        setCmd(17, 8'h90, Y_VAL, 12);
        setCmd(33, 8'hD0, X_VAL, 12);
        valid_mark = valid_total;
        applyStimulus(1, 56, 1'b0);
        checkOutput("ovl_valid_cnt", 32'(valid_total - valid_mark), 32'd3);
        checkWord("ovl_word0", 10);
        checkWord("ovl_word1", 26);
        checkWord("ovl_word2", 42);

        // A byte completing mid-word abandons the last four bits of the old word
        clearBits();
        setCmd(1, 8'hD0, 12'(X_VAL >> 4), 8);
        setCmd(10, 8'h90, Y_VAL, 12);
        applyStimulus(1, 32, 1'b0);
        checkWord("abandon_old", 10);
        checkOutput("abandon_gap", 32'(miso_bits[17]), 32'd0);
        checkWord("abandon_new", 19);

        // Deselect during CONV clears busy
        clearBits();
        setCmd(1, 8'hD0, 12'h000, 0);
        applyStimulus(1, 8, 1'b0);
        checkOutput("abort_conv_busy_pre", 32'(busy), 32'd1);
        spi_ss_n = 1'b1;
        repeat (HALF) @(negedge clk_clk);
        checkOutput("abort_conv_busy", 32'(busy), 32'd0);
        checkOutput("abort_cmd_hold", 32'(cmd_byte), 32'hD0);

        // Deselect during SHIFT clears MISO; IRQ enable is kept
        spi_ss_n = 1'b0;
        repeat (HALF) @(negedge clk_clk);
        clearBits();
        setCmd(1, 8'hD0, 12'(X_VAL >> 8), 4);
        applyStimulus(1, 14, 1'b0);
        checkWord("abort_part", 10);
        checkOutput("abort_miso_pre", 32'(spi_miso), 32'(X_VAL[6]));
        spi_ss_n = 1'b1;
        repeat (HALF) @(negedge clk_clk);
        checkOutput("abort_miso", 32'(spi_miso), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_irq_hold", 32'(pen_irq_n), 32'd0);

        // SS_n falling together with the first SCLK rise: the start bit is accepted
        clearBits();
        setCmd(1, 8'hD0, X_VAL, 12);
        applyStimulus(1, 24, 1'b1);
        checkWord("ss_rise_word", 10);

        // Reset in the middle of a control byte
        clearBits();
        setCmd(1, 8'hD0, 12'h000, 0);
        applyStimulus(1, 5, 1'b0);
        reset_reset_n = 1'b0;
        repeat (4) @(negedge clk_clk);
        checkOutput("midrst_cmd_byte", 32'(cmd_byte), 32'h00);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        reset_reset_n = 1'b1;
        repeat (HALF) @(negedge clk_clk);
        clearBits();
        setCmd(1, 8'hD0, X_VAL, 12);
        valid_mark = valid_total;
        applyStimulus(1, 24, 1'b0);
        checkOutput("midrst_valid_cnt", 32'(valid_total - valid_mark), 32'd1);
        checkWord("midrst_word", 10);

        // Channel map with pen up
        pen_down = 1'b0;
        clearBits();
        setCmd(1, 8'hD0, 12'h000, 12);
        setCmd(25, 8'hC0, 12'hFFF, 12);
        setCmd(49, 8'h80, 12'h2A0, 12);
        applyStimulus(1, 64, 1'b0);
        checkWord("map_x_penup", 10);
        checkWord("map_z2_penup", 34);
        checkWord("map_temp0", 58);

        // Channel map with pen down, including the optional channels
        pen_down = 1'b1;
        clearBits();
        setCmd(1, 8'hB0, Z1_VAL, 12);
        setCmd(25, 8'hC0, Z2_VAL, 12);
`ifdef TOUCH_PANEL_RESPONDER_AUX_EN
        setCmd(49, 8'hE0, 12'h400, 12);
`else
        setCmd(49, 8'hE0, 12'h000, 12);
`endif
        applyStimulus(1, 64, 1'b0);
        checkWord("map_z1", 10);
        checkWord("map_z2", 34);
        checkWord("map_aux", 58);

        clearBits();
`ifdef TOUCH_PANEL_RESPONDER_AUX_EN
        setCmd(1, 8'hF4, 12'h2E0, 12);
        setCmd(25, 8'hA0, 12'h800, 12);
`else
        setCmd(1, 8'hF4, 12'h000, 12);
        setCmd(25, 8'hA0, 12'h000, 12);
`endif
        applyStimulus(1, 48, 1'b0);
        checkWord("map_temp1", 10);
        checkWord("map_vbat", 34);

        checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
